// File: rtl/axi4_pkg.sv
// Shared AXI4 write-master definitions: response/burst codes, FSM states, AxSIZE helper.
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_e;

    // AxSIZE encoding for a bus of the given byte width.
    function automatic logic [2:0] axsize(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/axi4_wr_master.sv
// Single-burst AXI4 write master: command -> AW -> W beats from din -> B -> done pulse.
// Optional B-response watchdog enabled by defining AXI4_WR_TIMEOUT_EN.
module axi4_wr_master
    import axi4_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [DATA_W-1:0]   din_data,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                busy
);

    localparam int unsigned STRB_W = DATA_W / 8;

    wr_state_e  state;
    logic [7:0] beat_idx;
    logic       all_loaded;

`ifdef AXI4_WR_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_cnt;
`endif

    assign AWSIZE  = axsize(STRB_W);
    assign AWBURST = BURST_INCR;
    assign WSTRB   = '1;
    assign busy    = (state != IDLE);
    // One-entry W stage: refill when empty or draining, until the last beat is loaded.
    assign din_ready = (state == DATA) && (!WVALID || WREADY) && !all_loaded;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            AWVALID    <= 1'b0;
            AWADDR     <= '0;
            AWLEN      <= '0;
            WVALID     <= 1'b0;
            WDATA      <= '0;
            WLAST      <= 1'b0;
            BREADY     <= 1'b0;
            done       <= 1'b0;
            done_resp  <= '0;
            beat_idx   <= '0;
            all_loaded <= 1'b0;
`ifdef AXI4_WR_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        AWADDR     <= cmd_addr;
                        AWLEN      <= cmd_len;
                        AWVALID    <= 1'b1;
                        beat_idx   <= '0;
                        all_loaded <= 1'b0;
                        cmd_ready  <= 1'b0;
                        state      <= ADDR;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ADDR: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (din_ready && din_valid) begin
                        WVALID <= 1'b1;
                        WDATA  <= din_data;
                        WLAST  <= (beat_idx == AWLEN);
                        // Index stops at AWLEN so 256-beat bursts never wrap the 8-bit counter.
                        if (beat_idx == AWLEN) all_loaded <= 1'b1;
                        else                   beat_idx   <= beat_idx + 8'd1;
                    end else if (WREADY) begin
                        WVALID <= 1'b0;
                        WLAST  <= 1'b0;
                    end
                    if (WVALID && WREADY && WLAST) begin
                        BREADY <= 1'b1;
                        state  <= RESP;
`ifdef AXI4_WR_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                RESP: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        done      <= 1'b1;
                        done_resp <= BRESP;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
`ifdef AXI4_WR_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        BREADY    <= 1'b0;
                        done      <= 1'b1;
                        done_resp <= RESP_SLVERR;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_wr_master.sv
// Randomized bench for axi4_wr_master with a queue-based burst model and a reactive AXI slave.
module tb_axi4_wr_master;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMO    = 16;

    logic                ACLK = 1'b0;
    logic                ARESETn = 1'b0;
    logic                cmd_valid, cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [7:0]          cmd_len;
    logic                din_valid, din_ready;
    logic [DATA_W-1:0]   din_data;
    logic                AWVALID, AWREADY;
    logic [ADDR_W-1:0]   AWADDR;
    logic [7:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                WVALID, WREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                BVALID, BREADY;
    logic [1:0]          BRESP;
    logic                done;
    logic [1:0]          done_resp;
    logic                busy;

    always #5 ACLK = ~ACLK;

    axi4_wr_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .done(done), .done_resp(done_resp), .busy(busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model of the burst in flight.
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_len;
    logic [1:0]        m_bresp;
    logic [DATA_W-1:0] m_beats[$];
    logic [DATA_W-1:0] src_q[$];
    int  w_idx, awv_cnt, b_wait;
    bit  aw_done, w_done, b_mute;
    int  aw_mode, w_mode, din_mode, aw_hold;
    bit  aw_hs, w_hs, b_hs, din_hs;

    // Slave: checks AW/W against the model at negedge, drives READY/B after posedge.
    initial begin
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        forever begin
            @(negedge ACLK);
            aw_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0;
            if (ARESETn) begin
                aw_hs = AWVALID && AWREADY;
                w_hs  = WVALID && WREADY;
                b_hs  = BVALID && BREADY;
                if (AWVALID) begin
                    awv_cnt++;
                    check("awaddr", AWADDR, m_addr);
                    check("awlen", AWLEN, m_len);
                    check("awsize", AWSIZE, 3'($clog2(DATA_W / 8)));
                    check("awburst", AWBURST, 2'b01);
                end
                if (WVALID) begin
                    check("w_after_aw", aw_done, 1);
                    if (w_idx < m_beats.size()) begin
                        check("wdata", WDATA, m_beats[w_idx]);
                        check("wlast", WLAST, w_idx == int'(m_len));
                    end else begin
                        check("w_extra_beat", w_idx, m_beats.size() - 1);
                    end
                    check("wstrb", WSTRB, {(DATA_W/8){1'b1}});
                end
                if (aw_hs) aw_done = 1'b1;
                if (w_hs) begin
                    w_idx++;
                    if (WLAST) begin
                        w_done = 1'b1;
                        b_wait = $urandom_range(0, 3);
                    end
                end
                if (b_hs) w_done = 1'b0;
            end
            @(posedge ACLK);
            #1;
            case (aw_mode)
                0:       AWREADY = 1'b1;
                1:       AWREADY = 1'($urandom_range(0, 1));
                default: AWREADY = (awv_cnt >= aw_hold);
            endcase
            case (w_mode)
                0:       WREADY = 1'b1;
                1:       WREADY = 1'($urandom_range(0, 1));
                default: WREADY = ~WREADY;
            endcase
            if (BVALID) begin
                if (b_hs) BVALID = 1'b0;
            end else if (w_done && !b_mute) begin
                if (b_wait == 0) begin
                    BVALID = 1'b1;
                    BRESP  = m_bresp;
                end else begin
                    b_wait--;
                end
            end
        end
    end

    // Data source: feeds the burst payload in order with optional bubbles.
    initial begin
        din_valid = 1'b0; din_data = '0;
        forever begin
            @(negedge ACLK);
            din_hs = din_valid && din_ready;
            @(posedge ACLK);
            #1;
            if (din_hs && src_q.size() > 0) void'(src_q.pop_front());
            din_valid = (src_q.size() > 0) && (din_mode == 0 || $urandom_range(0, 1) == 1);
            din_data  = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [7:0] l, input logic [1:0] r,
                         input bit fixed, input logic [DATA_W-1:0] base, output int waited);
        logic [DATA_W-1:0] d;
        bit got;
        m_addr = a; m_len = l; m_bresp = r;
        m_beats.delete(); src_q.delete();
        for (int i = 0; i <= int'(l); i++) begin
            d = fixed ? base + DATA_W'(i) : DATA_W'($urandom);
            m_beats.push_back(d);
            src_q.push_back(d);
        end
        w_idx = 0; awv_cnt = 0; aw_done = 1'b0; w_done = 1'b0;
        cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        got = 1'b0; waited = 0;
        for (int c = 0; c < 100; c++) begin
            if (cmd_ready) begin got = 1'b1; break; end
            waited++;
            @(negedge ACLK);
        end
        check("cmd_accept", got, 1);
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
        check("busy_after_cmd", busy, 1);
    endtask

    task automatic wait_done(input logic [1:0] r, output int resp_cyc);
        bit got;
        got = 1'b0; resp_cyc = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge ACLK);
            if (done) begin got = 1'b1; break; end
            if (BREADY) resp_cyc++;
        end
        check("done_seen", got, 1);
        check("done_resp", done_resp, r);
        check("beat_count", w_idx, int'(m_len) + 1);
        @(negedge ACLK);
        check("done_pulse", done, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    task automatic check_reset_outs();
        check("rst_awvalid", AWVALID, 0);
        check("rst_wvalid", WVALID, 0);
        check("rst_wlast", WLAST, 0);
        check("rst_bready", BREADY, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_din_ready", din_ready, 0);
        check("rst_cmd_ready", cmd_ready, 0);
    endtask

    int  waited, rc, len_r;
    bit  got;

    initial begin
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        aw_mode = 0; w_mode = 0; din_mode = 0; aw_hold = 0; b_mute = 1'b0;
        w_idx = 0; awv_cnt = 0; b_wait = 0; aw_done = 1'b0; w_done = 1'b0;
        m_addr = '0; m_len = '0; m_bresp = '0;
        repeat (3) @(negedge ACLK);
        check_reset_outs();
        check("rst_awaddr", AWADDR, 0);
        check("rst_done_resp", done_resp, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Single beat, all ready.
        issue(32'h100, 8'd0, 2'b00, 1'b0, '0, waited);
        wait_done(2'b00, rc);

        // Four beats with WREADY toggling.
        w_mode = 2;
        issue(32'h2000, 8'd3, 2'b00, 1'b1, 32'hA0, waited);
        wait_done(2'b00, rc);

        // AWREADY held low for 5 AWVALID cycles.
        w_mode = 0; aw_mode = 2; aw_hold = 5;
        issue(32'h3000, 8'd2, 2'b01, 1'b0, '0, waited);
        wait_done(2'b01, rc);
        check("aw_stall_cycles", awv_cnt, aw_hold + 1);

        // SLVERR passthrough then immediate back-to-back command.
        aw_mode = 0;
        issue(32'h4000, 8'd1, 2'b10, 1'b0, '0, waited);
        wait_done(2'b10, rc);
        issue(32'h4100, 8'd0, 2'b11, 1'b0, '0, waited);
        check("b2b_no_wait", waited, 0);
        wait_done(2'b11, rc);

        // Maximum 256-beat burst.
        w_mode = 1; din_mode = 1;
        issue(32'h8000, 8'd255, 2'b00, 1'b0, '0, waited);
        wait_done(2'b00, rc);

        // Reset in the middle of a len=7 burst.
        w_mode = 0; din_mode = 0;
        issue(32'h5000, 8'd7, 2'b00, 1'b0, '0, waited);
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge ACLK);
            if (w_idx >= 2) begin got = 1'b1; break; end
        end
        check("reached_beat2", got, 1);
        ARESETn = 1'b0;
        #1;
        check_reset_outs();
        src_q.delete(); aw_done = 1'b0; w_done = 1'b0; BVALID = 1'b0;
        repeat (3) @(negedge ACLK);
        check_reset_outs();
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("rerst_cmd_ready", cmd_ready, 1);
        issue(32'h6000, 8'd1, 2'b00, 1'b0, '0, waited);
        wait_done(2'b00, rc);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            aw_mode  = $urandom_range(0, 1);
            w_mode   = $urandom_range(0, 2);
            din_mode = $urandom_range(0, 1);
            len_r    = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 63) : $urandom_range(0, 15);
            issue(ADDR_W'($urandom), 8'(len_r), 2'($urandom_range(0, 3)), 1'b0, '0, waited);
            wait_done(m_bresp, rc);
        end

`ifdef AXI4_WR_TIMEOUT_EN
        // Watchdog: B never arrives.
        aw_mode = 0; w_mode = 0; din_mode = 0; b_mute = 1'b1;
        issue(32'h7000, 8'd0, 2'b10, 1'b0, '0, waited);
        wait_done(2'b10, rc);
        check("timeout_resp_cycles", rc, TMO);
        b_mute = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
